frame_fifo_v2: RTL and testbench
================================

// Module: frame_fifo_v2
// PURPOSE
//  Parametrised frame-oriented message FIFO: stores variable-length frames (1 SOF-tagged entry per word)
//  between a producer frame interface and a consumer byte-pull interface. Commit-on-end: the reader only
//  ever sees complete frames. Overflowing frames are dropped and flagged; an optional length field is
//  back-patched into each frame before commit. Sits between bus/event capture and the host uplink.
// PARAMETERS
//  DATA_W      8   data word width
//  DEPTH_LOG2  8   log2 of storage entries; usable capacity DEPTH-1 words
//  LEN_EN      1   1 = length back-patch supported (still gated per frame by populate_frame_length)
//  LEN_OFFSET  2   word offset from SOF word of first (most significant) length word
//  LEN_WORDS   2   number of length words; LEN_W = LEN_WORDS*DATA_W
// PORTS
//  clk                   in   1           clock
//  rst                   in   1           synchronous active-high reset
//  in_data               in   DATA_W      producer data
//  in_data_latch         in   1           write in_data (non-first words) while recording
//  in_frame_valid        in   1           frame envelope; rising edge writes in_data as SOF word
//  populate_frame_length in   1           sampled on falling edge of in_frame_valid: patch length
//  in_frame_drop         out  1           1-cycle pulse: current/new frame discarded
//  out_data              out  DATA_W      word at tail (combinational from RAM)
//  out_sof               out  1           word at tail is first word of a frame
//  out_eof               out  1           word at tail is last committed word of its frame
//  out_frame_valid       out  1           >=1 committed frame pending (tail word is valid)
//  out_data_latch        in   1           consume word at tail; ignored when out_frame_valid=0
//  frames_pending        out  DEPTH_LOG2  committed, not fully consumed frames
//  free_entries          out  DEPTH_LOG2  (DEPTH-1) - (wr_ptr - tail)
// BEHAVIOUR
//  Reset: wr_ptr=commit_ptr=frame_start=tail=0, frames_pending=0, state IDLE, in_frame_drop=0,
//   out_frame_valid=0, free_entries=DEPTH-1, len_cnt=0. Reset mid-frame discards it, no drop pulse.
//  Pointers DEPTH_LOG2 wide, wrap mod DEPTH. full = (wr_ptr - tail == DEPTH-1). RAM entry = {sof, data}.
//  FSM IDLE/RECORD/PATCH/DISCARD; edge detect uses registered in_frame_valid.
//  IDLE: rising edge -> if full: drop pulse, DISCARD; else write {1,in_data}, frame_start=wr_ptr,
//   wr_ptr+1, len_cnt=1, RECORD. in_data_latch in the rising-edge cycle is ignored.
//  RECORD (in_frame_valid=1): in_data_latch -> if full: pulse drop, wr_ptr=commit_ptr, DISCARD;
//   else write {0,in_data}, wr_ptr+1, len_cnt+1 (saturates at 2^LEN_W-1).
//  RECORD, in_frame_valid=0: in_data_latch ignored. If LEN_EN && populate_frame_length &&
//   len_cnt >= LEN_OFFSET+LEN_WORDS -> PATCH; else commit_ptr=wr_ptr, frames_pending+1, IDLE.
//  PATCH: LEN_WORDS cycles, cycle i writes {0, len_cnt word i (MSW first)} at frame_start+LEN_OFFSET+i;
//   after last, commit (as above), IDLE. Patch never alters sof bits.
//  DISCARD: writes ignored; on in_frame_valid=0 -> IDLE. No commit, frames_pending unchanged.
//  Rising edge of in_frame_valid in PATCH: new frame dropped (pulse), DISCARD entered after patch commits.
//  Read: out_data/out_sof = RAM[tail]; out_frame_valid = (frames_pending != 0).
//   out_eof = (tail+1 == commit_ptr) || RAM[tail+1].sof (evaluated only when out_frame_valid=1).
//   out_data_latch && out_frame_valid -> tail+1; if out_eof, frames_pending-1.
//  Reader never passes commit_ptr; uncommitted words invisible. Simultaneous commit and last-word
//   consume -> frames_pending unchanged. Read and write in same cycle both take effect; full uses
//   pre-update pointers (a read never frees space for a same-cycle write).
//  Latency: committed frame visible (out_frame_valid=1) the cycle after commit.
// TESTING
//  1 frame A0,01,02,03,04, populate=0 -> frames_pending=1; reads give sof on A0, eof on 04, pending->0.
//  populate=1, 6-word frame 55,00,00,00,11,22 -> reads 55,00,00,06,11,22; 2-word frame populate=1 -> no patch.
//  DEPTH_LOG2=4: 20-word frame -> drop pulse at 16th write, wr_ptr rewinds, frames_pending=0, free=15.
//  Fill to 14 used, drain, repeat 3x -> wrap correct, data/sof intact, out_eof at each frame boundary.
//  Commit cycle coincides with consuming last word of prior frame -> frames_pending stays 1.
//  rst asserted mid-RECORD with 1 frame pending -> all outputs reset values, next frame stored at 0.

Source files
------------

// File: rtl/frame_fifo_v2.sv
`default_nettype none
// ============================================================================
// frame_fifo_v2 : commit-on-end frame FIFO with optional length back-patch
// Rev 1.0
// ============================================================================
module frame_fifo_v2 #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 8,
   parameter int LEN_EN     = 1,
   parameter int LEN_OFFSET = 2,
   parameter int LEN_WORDS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_data_latch,
   input  logic                  in_frame_valid,
   input  logic                  populate_frame_length,
   output logic                  in_frame_drop,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_sof,
   output logic                  out_eof,
   output logic                  out_frame_valid,
   input  logic                  out_data_latch,
   output logic [DEPTH_LOG2-1:0] frames_pending,
   output logic [DEPTH_LOG2-1:0] free_entries
);

   localparam int LEN_W  = LEN_WORDS * DATA_W;
   localparam int PIDX_W = (LEN_WORDS > 1) ? $clog2(LEN_WORDS) : 1;

   localparam logic [LEN_W-1:0]      LEN_MIN   = LEN_W'(LEN_OFFSET + LEN_WORDS);
   localparam logic [LEN_W-1:0]      LEN_ONE   = LEN_W'(1);
   localparam logic [PIDX_W-1:0]     PIDX_LAST = PIDX_W'(LEN_WORDS - 1);
   localparam logic [PIDX_W-1:0]     PIDX_ONE  = PIDX_W'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] LEN_OFS   = DEPTH_LOG2'(LEN_OFFSET);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RECORD  = 2'd1;
   localparam logic [1:0] S_PATCH   = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] commit_ptr;
   logic [DEPTH_LOG2-1:0] frame_start;
   logic [DEPTH_LOG2-1:0] tail;
   logic [DEPTH_LOG2-1:0] tail_nxt;
   logic [DEPTH_LOG2-1:0] used;
   logic [LEN_W-1:0]      len_cnt;
   logic [PIDX_W-1:0]     patch_idx;
   logic [DATA_W-1:0]     patch_word;
   logic                  fv_q;
   logic                  drop_pend;

   logic                  rise;
   logic                  full;
   logic                  patch_ok;
   logic                  patch_last;
   logic                  consume;

   logic                  wr_en;
   logic                  wr_sof_en;
   logic                  wr_sof;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DATA_W-1:0]     wr_word;
   logic                  drop_now;
   logic                  start_frame;
   logic                  adv_wr;
   logic                  rewind;
   logic                  commit;
   logic                  patch_step;

   logic [DATA_W-1:0]     data_mem [0:(1<<DEPTH_LOG2)-1];
   logic                  sof_mem  [0:(1<<DEPTH_LOG2)-1];

   assign rise       = in_frame_valid & ~fv_q;
   assign used       = wr_ptr - tail;
   assign full       = (used == '1);
   // all-ones minus used, i.e. (DEPTH-1) - used
   assign free_entries = ~used;
   assign patch_ok   = (LEN_EN != 0) && populate_frame_length && (len_cnt >= LEN_MIN);
   assign patch_last = (patch_idx == PIDX_LAST);

   assign tail_nxt        = tail + PTR_ONE;
   assign out_frame_valid = (frames_pending != '0);
   assign out_data        = data_mem[tail];
   assign out_sof         = sof_mem[tail];
   assign out_eof         = out_frame_valid && ((tail_nxt == commit_ptr) || sof_mem[tail_nxt]);
   assign consume         = out_data_latch && out_frame_valid;

   always_comb begin
      patch_word = '0;
      for (int i = 0; i < LEN_WORDS; i++) begin
         if (patch_idx == PIDX_W'(i)) begin
            patch_word = len_cnt[(LEN_WORDS-1-i)*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (rise) state_nxt = full ? S_DISCARD : S_RECORD;
         end
         S_RECORD: begin
            if (!in_frame_valid) state_nxt = patch_ok ? S_PATCH : S_IDLE;
            else if (in_data_latch && full) state_nxt = S_DISCARD;
         end
         S_PATCH: begin
            if (patch_last) state_nxt = (drop_pend || rise) ? S_DISCARD : S_IDLE;
         end
         default: begin
            if (!in_frame_valid) state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_en       = 1'b0;
      wr_sof_en   = 1'b0;
      wr_sof      = 1'b0;
      wr_addr     = wr_ptr;
      wr_word     = in_data;
      drop_now    = 1'b0;
      start_frame = 1'b0;
      adv_wr      = 1'b0;
      rewind      = 1'b0;
      commit      = 1'b0;
      patch_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) begin
               if (full) begin
                  drop_now = 1'b1;
               end else begin
                  wr_en       = 1'b1;
                  wr_sof_en   = 1'b1;
                  wr_sof      = 1'b1;
                  start_frame = 1'b1;
                  adv_wr      = 1'b1;
               end
            end
         end
         S_RECORD: begin
            if (in_frame_valid) begin
               if (in_data_latch) begin
                  if (full) begin
                     drop_now = 1'b1;
                     rewind   = 1'b1;
                  end else begin
                     wr_en     = 1'b1;
                     wr_sof_en = 1'b1;
                     adv_wr    = 1'b1;
                  end
               end
            end else if (!patch_ok) begin
               commit = 1'b1;
            end
         end
         S_PATCH: begin
            // patch touches only the data array so SOF tags stay intact
            wr_en      = 1'b1;
            wr_addr    = frame_start + LEN_OFS + DEPTH_LOG2'(patch_idx);
            wr_word    = patch_word;
            patch_step = 1'b1;
            drop_now   = rise;
            commit     = patch_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) data_mem[wr_addr] <= wr_word;
      if (wr_sof_en) sof_mem[wr_addr] <= wr_sof;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         commit_ptr     <= '0;
         frame_start    <= '0;
         tail           <= '0;
         frames_pending <= '0;
         len_cnt        <= '0;
         patch_idx      <= '0;
         fv_q           <= 1'b0;
         drop_pend      <= 1'b0;
         in_frame_drop  <= 1'b0;
      end else begin
         fv_q          <= in_frame_valid;
         in_frame_drop <= drop_now;
         drop_pend     <= (state == S_PATCH) && !patch_last && (drop_pend || rise);
         patch_idx     <= (patch_step && !patch_last) ? patch_idx + PIDX_ONE : '0;

         if (adv_wr) wr_ptr <= wr_ptr + PTR_ONE;
         else if (rewind) wr_ptr <= commit_ptr;

         if (start_frame) begin
            frame_start <= wr_ptr;
            len_cnt     <= LEN_ONE;
         end else if (adv_wr && (len_cnt != '1)) begin
            len_cnt <= len_cnt + LEN_ONE;
         end

         if (commit) commit_ptr <= wr_ptr;
         if (consume) tail <= tail_nxt;

         case ({commit, consume && out_eof})
            2'b10:   frames_pending <= frames_pending + PTR_ONE;
            2'b01:   frames_pending <= frames_pending - PTR_ONE;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_fifo_v2.sv
`default_nettype none
// tb_frame_fifo_v2 : scoreboard bench for frame_fifo_v2 (DEPTH_LOG2=4, capacity 15)
// Rev 1.0
module tb_frame_fifo_v2;

   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int LEN_EN     = 1;
   localparam int LEN_OFFSET = 2;
   localparam int LEN_WORDS  = 2;
   localparam int CAP        = (1 << DEPTH_LOG2) - 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [DATA_W-1:0]     in_data;
   logic                  in_data_latch;
   logic                  in_frame_valid;
   logic                  populate_frame_length;
   logic                  in_frame_drop;
   logic [DATA_W-1:0]     out_data;
   logic                  out_sof;
   logic                  out_eof;
   logic                  out_frame_valid;
   logic                  out_data_latch;
   logic [DEPTH_LOG2-1:0] frames_pending;
   logic [DEPTH_LOG2-1:0] free_entries;

   always #5 clk = ~clk;

   frame_fifo_v2 #(
      .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LEN_EN(LEN_EN),
      .LEN_OFFSET(LEN_OFFSET), .LEN_WORDS(LEN_WORDS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_data_latch(in_data_latch),
      .in_frame_valid(in_frame_valid), .populate_frame_length(populate_frame_length),
      .in_frame_drop(in_frame_drop),
      .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
      .out_frame_valid(out_frame_valid), .out_data_latch(out_data_latch),
      .frames_pending(frames_pending), .free_entries(free_entries)
   );

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sof;
      logic              eof;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks   = 0;
   int          n_fail     = 0;
   int          pushed     = 0;
   int          popped     = 0;
   int          drops_seen = 0;
   int          drops_exp  = 0;
   int          rd_prob    = 0;
   logic        rd_force   = 1'b0;
   logic [7:0]  fw [0:31];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_frame_valid = 1'b0;
      in_data_latch  = 1'b0;
      repeat (n) tick();
   endtask

   // Reader: random or forced pulls, driven a little after the producer
   initial begin
      out_data_latch = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_data_latch = rd_force || ($urandom_range(0, 99) < rd_prob);
      end
   end

   // Monitor: every accepted pull is compared against the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         if (in_frame_drop) drops_seen++;
         if (out_frame_valid && out_data_latch) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rd_unexpected: got word %0h, expected no word", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               popped++;
               check("rd_data", int'(out_data), int'(mon_e.data));
               check("rd_sof", int'(out_sof), int'(mon_e.sof));
               check("rd_eof", int'(out_eof), int'(mon_e.eof));
            end
         end
      end
   end

   // Drives one frame from fw[0..len-1]; the expected image is pushed at its end
   task automatic send_frame(input int len, input bit pop, input bit force_drop,
                             input bit rd_on_commit, input int gap_max);
      bit         drop;
      exp_t       e;
      logic [7:0] pw [0:31];
      drop = force_drop || ((pushed - popped + len) > CAP);
      in_frame_valid = 1'b1;
      in_data        = fw[0];
      in_data_latch  = 1'($urandom_range(0, 1));
      tick();
      for (int i = 1; i < len; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            in_data_latch = 1'b0;
            in_data       = 8'($urandom);
            tick();
         end
         in_data       = fw[i];
         in_data_latch = 1'b1;
         tick();
      end
      in_frame_valid        = 1'b0;
      in_data_latch         = 1'($urandom_range(0, 1));
      in_data               = 8'($urandom);
      populate_frame_length = pop;
      rd_force              = rd_on_commit;
      if (!drop) begin
         for (int i = 0; i < len; i++) pw[i] = fw[i];
         if (pop && LEN_EN != 0 && len >= LEN_OFFSET + LEN_WORDS) begin
            for (int j = 0; j < LEN_WORDS; j++)
               pw[LEN_OFFSET+j] = 8'((len >> (8 * (LEN_WORDS - 1 - j))) & 255);
         end
         for (int i = 0; i < len; i++) begin
            e.data = pw[i];
            e.sof  = (i == 0);
            e.eof  = (i == len - 1);
            exp_q.push_back(e);
         end
         pushed += len;
      end else begin
         drops_exp++;
      end
      tick();
      in_data_latch         = 1'b0;
      rd_force              = 1'b0;
      populate_frame_length = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int budget;
      budget  = 0;
      rd_prob = 100;
      while (exp_q.size() != 0 && budget < 1000) begin
         tick();
         budget++;
      end
      check("drain_complete", exp_q.size(), 0);
      rd_prob = 0;
      idle(2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                   = 1'b1;
      in_data               = '0;
      in_data_latch         = 1'b0;
      in_frame_valid        = 1'b0;
      populate_frame_length = 1'b0;
      repeat (3) tick();
      check("rst_pending", int'(frames_pending), 0);
      check("rst_valid", int'(out_frame_valid), 0);
      check("rst_free", int'(free_entries), CAP);
      check("rst_drop", int'(in_frame_drop), 0);
      rst = 1'b0;
      idle(2);

      // plain frame, visible the cycle after commit
      fw[0] = 8'hA0;
      for (int i = 1; i < 5; i++) fw[i] = 8'(i);
      send_frame(5, 1'b0, 1'b0, 1'b0, 2);
      check("f1_pending", int'(frames_pending), 1);
      check("f1_valid", int'(out_frame_valid), 1);
      check("f1_head", int'(out_data), 8'hA0);
      check("f1_free", int'(free_entries), CAP - 5);
      idle(2);
      drain();
      check("f1_pending_after", int'(frames_pending), 0);
      check("f1_free_after", int'(free_entries), CAP);

      // length back-patch, and a frame too short to patch
      fw[0] = 8'h55; fw[1] = 8'h00; fw[2] = 8'h00;
      fw[3] = 8'h00; fw[4] = 8'h11; fw[5] = 8'h22;
      send_frame(6, 1'b1, 1'b0, 1'b0, 1);
      idle(3);
      fw[0] = 8'hAA; fw[1] = 8'hBB;
      send_frame(2, 1'b1, 1'b0, 1'b0, 1);
      idle(3);
      check("patch_pending", int'(frames_pending), 2);
      drain();

      // new frame started while the previous one is being patched
      fw[0] = 8'h10; fw[1] = 8'h20; fw[2] = 8'h30; fw[3] = 8'h40;
      send_frame(4, 1'b1, 1'b0, 1'b0, 0);
      fw[0] = 8'hE0; fw[1] = 8'hE1; fw[2] = 8'hE2;
      send_frame(3, 1'b0, 1'b1, 1'b0, 0);
      idle(3);
      check("patch_drop_cnt", drops_seen, drops_exp);
      check("patch_drop_pending", int'(frames_pending), 1);
      drain();

      // overflow mid-frame, exact fill, then overflow at SOF
      for (int i = 0; i < 20; i++) fw[i] = 8'(8'h60 + i);
      send_frame(20, 1'b0, 1'b0, 1'b0, 0);
      idle(3);
      check("ovf_drop_cnt", drops_seen, drops_exp);
      check("ovf_pending", int'(frames_pending), 0);
      check("ovf_free", int'(free_entries), CAP);
      send_frame(15, 1'b0, 1'b0, 1'b0, 0);
      idle(3);
      check("fill_free", int'(free_entries), 0);
      check("fill_pending", int'(frames_pending), 1);
      fw[0] = 8'h99;
      send_frame(1, 1'b0, 1'b0, 1'b0, 0);
      idle(3);
      check("sof_drop_cnt", drops_seen, drops_exp);
      check("sof_drop_free", int'(free_entries), 0);
      drain();

      // wrap: fill to 14, drain, repeat
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 7; i++) fw[i] = 8'($urandom);
            send_frame(7, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1);
            idle(3);
         end
         check("wrap_free", int'(free_entries), 1);
         check("wrap_pending", int'(frames_pending), 2);
         drain();
         check("wrap_free_after", int'(free_entries), CAP);
      end

      // commit coincides with consuming the last word of the prior frame
      fw[0] = 8'hB0; fw[1] = 8'hB1;
      send_frame(2, 1'b0, 1'b0, 1'b0, 0);
      idle(2);
      rd_force = 1'b1;
      tick();
      rd_force = 1'b0;
      fw[0] = 8'hC0; fw[1] = 8'hC1; fw[2] = 8'hC2;
      send_frame(3, 1'b0, 1'b0, 1'b1, 0);
      check("coincide_pending", int'(frames_pending), 1);
      check("coincide_head", int'(out_data), 8'hC0);
      idle(2);
      drain();

      // reset in the middle of a frame with one frame pending
      fw[0] = 8'hD0; fw[1] = 8'hD1; fw[2] = 8'hD2;
      send_frame(3, 1'b0, 1'b0, 1'b0, 0);
      idle(2);
      in_frame_valid = 1'b1; in_data = 8'hF0; tick();
      in_data_latch = 1'b1; in_data = 8'hF1; tick();
      rst = 1'b1; in_frame_valid = 1'b0; in_data_latch = 1'b0;
      tick();
      check("mid_rst_pending", int'(frames_pending), 0);
      check("mid_rst_valid", int'(out_frame_valid), 0);
      check("mid_rst_free", int'(free_entries), CAP);
      check("mid_rst_drop", int'(in_frame_drop), 0);
      rst = 1'b0;
      exp_q.delete();
      pushed = 0;
      popped = 0;
      idle(2);
      fw[0] = 8'h71; fw[1] = 8'h72; fw[2] = 8'h73; fw[3] = 8'h74;
      send_frame(4, 1'b0, 1'b0, 1'b0, 0);
      idle(2);
      check("post_rst_free", int'(free_entries), CAP - 4);
      check("post_rst_head", int'(out_data), 8'h71);
      drain();

      // random traffic with a concurrent reader; producer respects capacity
      for (int f = 0; f < 40; f++) begin
         int len;
         int budget;
         len     = $urandom_range(1, 9);
         rd_prob = $urandom_range(20, 90);
         for (int i = 0; i < len; i++) fw[i] = 8'($urandom);
         budget = 0;
         while ((pushed - popped + len) > CAP && budget < 500) begin
            tick();
            budget++;
         end
         if (budget >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_space: got no space after %0d cycles, expected space for %0d words", budget, len);
         end
         send_frame(len, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2);
         idle($urandom_range(2, 4));
      end
      drain();

      check("final_drops", drops_seen, drops_exp);
      check("final_pending", int'(frames_pending), 0);
      check("final_free", int'(free_entries), CAP);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
